// File: rtl/instr_route.sv
// instr_route -- dual-pipe instruction router.
//
// Accepts an instruction pair from fetch (instr1 older, at pc; instr2 at pc+4),
// drops NOPs, and issues the remaining instructions in program order to an
// EVEN pipe and an ODD pipe, dual-issuing an opposite-class pair when both
// pipes are free.
//
// Instruction bits are numbered big-endian: bit 0 is the MSB (instr[31]).
//   NOP : bits [0:10] == 11'b00000000001   (instr[31:21])
//   ODD : bits [0:2]  == 3'b001            (instr[31:29]), not NOP
//   EVEN: any other non-NOP instruction
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   in_valid, in_ready      fetch handshake (see below)
//   instr1, instr2, pc      fetched pair and address of instr1
//   flush                   discards buffered and issued-but-unconsumed work
//   even_stall, odd_stall   downstream pipe cannot accept a new instruction
//   even_valid/instr/pc     EVEN pipe output register
//   odd_valid/instr/pc      ODD pipe output register
//   dbg_state               current FSM state, for checkers
//   dual_cnt, split_cnt     performance counters (only with ROUTE_PERF_CNT_EN)
//
// Optional feature macro: ROUTE_PERF_CNT_EN adds dual_cnt (dual-issue edges)
// and split_cnt (same-class PAIR->ONE transitions). Both are cleared by reset
// only, never by flush.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational: high when the buffer is empty or is fully drained
// on this edge, and always low while flush is high. Fetch stalls on !in_ready.
// Each pipe output register changes only when its stall input is low.

module instr_route (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  input  logic [31:0] pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        even_stall,
  input  logic        odd_stall,
  output logic        even_valid,
  output logic        odd_valid,
  output logic [31:0] even_instr,
  output logic [31:0] odd_instr,
  output logic [31:0] even_pc,
  output logic [31:0] odd_pc,
  output logic [1:0]  dbg_state
`ifdef ROUTE_PERF_CNT_EN
  ,
  output logic [31:0] dual_cnt,
  output logic [31:0] split_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PAIR  = 2'd1,
    S_ONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_s0_instr, r_s0_pc;
  logic [31:0] r_s1_instr, r_s1_pc;

  logic        w_n0, w_n1, w_o0, w_o1;
  logic        w_empty_drain;   // buffer already empty / both NOPs
  logic        w_single;        // exactly one instruction is a candidate
  logic        w_single_drains; // issuing that candidate empties the buffer
  logic [31:0] w_sel_instr, w_sel_pc;
  logic        w_sel_odd;
  logic        w_single_ok;
  logic        w_dual_ok;
  logic        w_drain;
  logic        w_split;
  logic        w_accept;
  logic        w_iss_even, w_iss_odd;
  logic [31:0] w_even_instr, w_even_pc, w_odd_instr, w_odd_pc;

  function automatic logic is_nop(input logic [31:0] x);
    return x[31:21] == 11'b00000000001;
  endfunction

  function automatic logic is_odd(input logic [31:0] x);
    return x[31:29] == 3'b001;
  endfunction

  assign w_n0 = is_nop(r_s0_instr);
  assign w_n1 = is_nop(r_s1_instr);
  assign w_o0 = is_odd(r_s0_instr);
  assign w_o1 = is_odd(r_s1_instr);

  // Pick what could issue this cycle. A pair with exactly one NOP is treated
  // like ONE holding the surviving instruction, so it drains in one issue.
  always_comb begin
    w_empty_drain   = 1'b0;
    w_single        = 1'b0;
    w_single_drains = 1'b0;
    w_sel_instr     = r_s1_instr;
    w_sel_pc        = r_s1_pc;
    w_dual_ok       = 1'b0;
    case (r_state)
      S_EMPTY: w_empty_drain = 1'b1;
      S_PAIR: begin
        if (w_n0 && w_n1) begin
          w_empty_drain = 1'b1;
        end else if (w_n0) begin
          w_single        = 1'b1;
          w_single_drains = 1'b1;
        end else if (w_n1) begin
          w_single        = 1'b1;
          w_single_drains = 1'b1;
          w_sel_instr     = r_s0_instr;
          w_sel_pc        = r_s0_pc;
        end else if (w_o0 != w_o1) begin
          // Opposite classes go together or not at all, keeping order.
          w_dual_ok = !even_stall && !odd_stall;
        end else begin
          w_single    = 1'b1;
          w_sel_instr = r_s0_instr;
          w_sel_pc    = r_s0_pc;
        end
      end
      S_ONE: begin
        if (w_n1) begin
          w_empty_drain = 1'b1;
        end else begin
          w_single        = 1'b1;
          w_single_drains = 1'b1;
        end
      end
      default: w_empty_drain = 1'b1;
    endcase
  end

  assign w_sel_odd   = is_odd(w_sel_instr);
  assign w_single_ok = w_single && (w_sel_odd ? !odd_stall : !even_stall);
  assign w_drain     = w_empty_drain || w_dual_ok || (w_single_ok && w_single_drains);
  assign w_split     = w_single_ok && !w_single_drains;

  assign w_iss_even   = w_dual_ok || (w_single_ok && !w_sel_odd);
  assign w_iss_odd    = w_dual_ok || (w_single_ok && w_sel_odd);
  assign w_even_instr = w_dual_ok ? (w_o0 ? r_s1_instr : r_s0_instr) : w_sel_instr;
  assign w_even_pc    = w_dual_ok ? (w_o0 ? r_s1_pc : r_s0_pc) : w_sel_pc;
  assign w_odd_instr  = w_dual_ok ? (w_o0 ? r_s0_instr : r_s1_instr) : w_sel_instr;
  assign w_odd_pc     = w_dual_ok ? (w_o0 ? r_s0_pc : r_s1_pc) : w_sel_pc;

  assign in_ready  = !flush && w_drain;
  assign w_accept  = in_valid && in_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_EMPTY;
      r_s0_instr <= '0;
      r_s0_pc    <= '0;
      r_s1_instr <= '0;
      r_s1_pc    <= '0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      even_instr <= '0;
      even_pc    <= '0;
      odd_instr  <= '0;
      odd_pc     <= '0;
`ifdef ROUTE_PERF_CNT_EN
      dual_cnt   <= '0;
      split_cnt  <= '0;
`endif
    end else if (flush) begin
      // Flush overrides stalls: issued-but-unconsumed work is discarded too.
      r_state    <= S_EMPTY;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state    <= S_PAIR;
        r_s0_instr <= instr1;
        r_s0_pc    <= pc;
        r_s1_instr <= instr2;
        r_s1_pc    <= pc + 32'd4;
      end else if (w_drain) begin
        r_state <= S_EMPTY;
      end else if (w_split) begin
        r_state <= S_ONE;
      end
      if (!even_stall) begin
        even_valid <= w_iss_even;
        if (w_iss_even) begin
          even_instr <= w_even_instr;
          even_pc    <= w_even_pc;
        end
      end
      if (!odd_stall) begin
        odd_valid <= w_iss_odd;
        if (w_iss_odd) begin
          odd_instr <= w_odd_instr;
          odd_pc    <= w_odd_pc;
        end
      end
`ifdef ROUTE_PERF_CNT_EN
      if (w_dual_ok) dual_cnt <= dual_cnt + 32'd1;
      if (w_split)   split_cnt <= split_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_instr_route.sv
// Testbench for instr_route: directed scenarios followed by random traffic,
// checked by a queue-based reference model and a decoupled output monitor.

module tb_instr_route;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr1 = '0, instr2 = '0, pc = '0;
  logic        flush = 1'b0, even_stall = 1'b0, odd_stall = 1'b0;
  logic        in_ready, even_valid, odd_valid;
  logic [31:0] even_instr, odd_instr, even_pc, odd_pc;
  logic [1:0]  dbg_state;
`ifdef ROUTE_PERF_CNT_EN
  logic [31:0] dual_cnt, split_cnt;
`endif

  instr_route dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .instr1(instr1), .instr2(instr2), .pc(pc), .in_ready(in_ready),
    .flush(flush), .even_stall(even_stall), .odd_stall(odd_stall),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .even_pc(even_pc), .odd_pc(odd_pc), .dbg_state(dbg_state)
`ifdef ROUTE_PERF_CNT_EN
    , .dual_cnt(dual_cnt), .split_cnt(split_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffered work is a program-order queue of non-NOP instructions.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        buf_q[$];
  logic [63:0] exp_even_q[$];
  logic [63:0] exp_odd_q[$];
  logic [31:0] m_dual = '0;
  logic [31:0] m_split = '0;

  function automatic bit m_nop(input logic [31:0] x);
    return x[31:21] == 11'd1;
  endfunction

  function automatic bit m_odd(input logic [31:0] x);
    return x[31:29] == 3'b001;
  endfunction

  task automatic m_push(input ent_t e);
    if (m_odd(e.instr)) exp_odd_q.push_back({e.instr, e.pc});
    else exp_even_q.push_back({e.instr, e.pc});
  endtask

  task automatic model_eval(input logic iv, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] p, input logic fl, input logic es,
                            input logic os, output logic rdy);
    ent_t e;
    if (fl) begin
      buf_q.delete();
      rdy = 1'b0;
      return;
    end
    if (buf_q.size() == 2 && (m_odd(buf_q[0].instr) != m_odd(buf_q[1].instr))) begin
      if (!es && !os) begin
        m_push(buf_q[0]);
        m_push(buf_q[1]);
        m_dual = m_dual + 32'd1;
        buf_q.delete();
      end
    end else if (buf_q.size() > 0) begin
      if (!(m_odd(buf_q[0].instr) ? os : es)) begin
        m_push(buf_q[0]);
        void'(buf_q.pop_front());
        if (buf_q.size() == 1) m_split = m_split + 32'd1;
      end
    end
    rdy = (buf_q.size() == 0);
    if (iv && rdy) begin
      e.instr = a; e.pc = p;
      if (!m_nop(a)) buf_q.push_back(e);
      e.instr = b; e.pc = p + 32'd4;
      if (!m_nop(b)) buf_q.push_back(e);
    end
  endtask

  task automatic model_clear();
    buf_q.delete();
    exp_even_q.delete();
    exp_odd_q.delete();
    m_dual = '0;
    m_split = '0;
  endtask

  // ---------------- driver ----------------
  // Called one time unit after a rising edge; returns one unit after the next.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic fl, input logic es, input logic os);
    logic rdy;
    in_valid = iv; instr1 = a; instr2 = b; pc = p;
    flush = fl; even_stall = es; odd_stall = os;
    #1;
    model_eval(iv, a, b, p, fl, es, os, rdy);
    check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; even_stall = 1'b0; odd_stall = 1'b0;
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valids", 64'({even_valid, odd_valid}), 64'd0);
    check("rst_even_out", {even_instr, even_pc}, 64'd0);
    check("rst_odd_out", {odd_instr, odd_pc}, 64'd0);
`ifdef ROUTE_PERF_CNT_EN
    check("rst_counters", {dual_cnt, split_cnt}, 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // A pipe register that was not stalled at an edge and shows valid holds a
  // newly issued instruction; it must match the oldest expected entry.
  logic c_es, c_os, c_rst;
  initial begin
    forever begin
      @(posedge clk);
      c_es = even_stall; c_os = odd_stall; c_rst = reset;
      @(negedge clk);
      if (!c_rst && !reset) begin
        if (!c_es && even_valid) begin
          if (exp_even_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL even_unexpected: got %h expected none", {even_instr, even_pc});
          end else begin
            check("even_out", {even_instr, even_pc}, exp_even_q.pop_front());
          end
        end
        if (!c_os && odd_valid) begin
          if (exp_odd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL odd_unexpected: got %h expected none", {odd_instr, odd_pc});
          end else begin
            check("odd_out", {odd_instr, odd_pc}, exp_odd_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    int r;
    r = $urandom_range(0, 5);
    x = $urandom;
    if (r == 0) x = {11'd1, x[20:0]};          // NOP
    else if (r < 3) x = {3'b001, x[28:0]};    // ODD
    else x[31] = 1'b1;                        // EVEN
    return x;
  endfunction

  localparam logic [31:0] EV  = 32'h0040_0000;
  localparam logic [31:0] OD  = 32'h2000_0000;
  localparam logic [31:0] NOP = 32'h0020_0000;

  // ---------------- main sequence ----------------
  initial begin
    #1;
    do_reset();

    // Opposite-class pair, no stalls: dual issue on the edge after acceptance.
    cycle(1'b1, EV, OD, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check("s1_valids", 64'({even_valid, odd_valid}), 64'b11);
    check("s1_pcs", {even_pc, odd_pc}, {32'h0, 32'h4});

    // Same-class pair: issue in two consecutive edges.
    cycle(1'b1, OD | 32'h1, OD | 32'h2, 32'h10, 1'b0, 1'b0, 1'b0);
    idle();
    check("s2_first_pc", 64'(odd_pc), 64'h10);
    idle();
    check("s2_second_pc", 64'(odd_pc), 64'h14);

    // NOP in the older slot: only the EVEN one issues.
    cycle(1'b1, NOP, EV | 32'h5, 32'h100, 1'b0, 1'b0, 1'b0);
    idle();
    check("s3_even", {31'd0, even_valid, even_pc}, {31'd0, 1'b1, 32'h104});
    check("s3_odd_valid", 64'(odd_valid), 64'd0);

    // Opposite-class pair with the ODD pipe stalled for three cycles.
    cycle(1'b1, OD | 32'h7, EV | 32'h7, 32'h200, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("s4_no_issue", 64'({even_valid, odd_valid}), 64'd0);
    end
    idle();
    check("s4_released", {even_pc, odd_pc}, {32'h204, 32'h200});

    // Stalled EVEN pipe holds its register contents.
    cycle(1'b1, EV | 32'h9, OD | 32'h9, 32'h280, 1'b0, 1'b0, 1'b0);
    idle();
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("hold_even", {31'd0, even_valid, even_pc}, {31'd0, 1'b1, 32'h280});
    check("odd_cleared", 64'(odd_valid), 64'd0);

    // PC wrap-around on the younger instruction.
    cycle(1'b1, OD | 32'h3, EV | 32'h3, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    idle();
    check("wrap_pc", 64'(even_pc), 64'h0);

    // Flush while in ONE with an EVEN instruction valid at the output.
    cycle(1'b1, EV | 32'h11, EV | 32'h12, 32'h300, 1'b0, 1'b0, 1'b0);
    idle();
    check("s5_pre", {31'd0, even_valid, even_pc}, {31'd0, 1'b1, 32'h300});
    cycle(1'b1, OD, EV, 32'h400, 1'b1, 1'b0, 1'b0);
    check("s5_flush_valids", 64'({even_valid, odd_valid}), 64'd0);
    idle();
    check("s5_not_accepted", 64'({even_valid, odd_valid}), 64'd0);

    // Counters: five dual pairs then two same-class pairs, then a reset pulse.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, EV | k, OD | k, 32'h500 + 32'(k * 8), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, OD | 32'h21, OD | 32'h22, 32'h600, 1'b0, 1'b0, 1'b0);
    idle();
    cycle(1'b1, EV | 32'h23, EV | 32'h24, 32'h700, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
`ifdef ROUTE_PERF_CNT_EN
    check("cnt_dual", 64'(dual_cnt), 64'd5);
    check("cnt_split", 64'(split_cnt), 64'd2);
`endif
    cycle(1'b1, EV | 32'h31, OD | 32'h32, 32'h800, 1'b0, 1'b0, 1'b0);
    idle();
    check("pre_pulse_valids", 64'({even_valid, odd_valid}), 64'b11);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle(($urandom_range(0, 2) != 0), rand_instr(), rand_instr(), p,
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0));
    end
    for (int k = 0; k < 4; k++) idle();
    check("even_q_drained", 64'(exp_even_q.size()), 64'd0);
    check("odd_q_drained", 64'(exp_odd_q.size()), 64'd0);
`ifdef ROUTE_PERF_CNT_EN
    check("rand_dual_cnt", 64'(dual_cnt), 64'(m_dual));
    check("rand_split_cnt", 64'(split_cnt), 64'(m_split));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
